// File: rtl/riscv_fetch_unit_pkg.sv
// rtl/riscv_fetch_unit_pkg.sv - shared constants for the riscv_fetch_unit slice
package riscv_fetch_unit_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam int          ILEN_DEFAULT = 32;
  localparam logic [31:0] PC_RESET     = 32'h0000_2000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  localparam int ENTRY_PC_W   = XLEN_DEFAULT;
  localparam int ENTRY_INST_W = ILEN_DEFAULT;
  localparam int ENTRY_W      = ENTRY_PC_W + ENTRY_INST_W;

endpackage

// File: rtl/riscv_fetch_unit_if.sv
// rtl/riscv_fetch_unit_if.sv - icache and decode-side signals of the fetch unit
interface riscv_fetch_unit_if #(
  parameter int XLEN = riscv_fetch_unit_pkg::XLEN_DEFAULT,
  parameter int ILEN = riscv_fetch_unit_pkg::ILEN_DEFAULT
) ();

  logic [XLEN-1:0] icache_addr;
  logic            icache_re;
  logic [ILEN-1:0] icache_dout;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output icache_addr, icache_re, inst_valid, inst, inst_pc,
    input  icache_dout, stall, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  icache_addr, icache_re, inst_valid, inst, inst_pc,
    output icache_dout, stall, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/riscv_fetch_unit_fetch_fifo.sv
// rtl/riscv_fetch_unit_fetch_fifo.sv - fetch buffer FIFO with synchronous flush and count
module riscv_fetch_unit_fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - PC generator, icache request tracker and fetch buffer
// Optional same-cycle response bypass to decode: FETCH_BYPASS_EN
module riscv_fetch_unit
  import riscv_fetch_unit_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEFAULT,
  parameter int              ILEN       = ILEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(PC_RESET),
  parameter int              FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                reset,
  riscv_fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = XLEN + ILEN;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            kill_q, kill_d;

  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   fifo_head;
  logic            fifo_empty, fifo_push, fifo_pop;
  logic            deq, accept, resp, resp_live;
  logic [CW:0]     occupancy;

  assign resp       = outstanding_q & ~bus.stall;
  assign resp_live  = resp & ~kill_q & ~bus.redirect_valid;
  assign fifo_empty = (fifo_count == '0);
  assign deq        = bus.inst_valid & bus.inst_ready;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  // Empty buffer: the returning word goes straight to decode and is only stored if decode stalls.
  assign bypass         = fifo_empty & resp_live;
  assign bus.inst_valid = ~bus.redirect_valid & (~fifo_empty | bypass);
  assign bus.inst       = bypass ? bus.icache_dout : fifo_head[ILEN-1:0];
  assign bus.inst_pc    = bypass ? req_pc_q : fifo_head[EW-1:ILEN];
  assign fifo_pop       = deq & ~fifo_empty;
  assign fifo_push      = resp_live & ~(bypass & bus.inst_ready);
`else
  assign bus.inst_valid = ~bus.redirect_valid & ~fifo_empty;
  assign bus.inst       = fifo_head[ILEN-1:0];
  assign bus.inst_pc    = fifo_head[EW-1:ILEN];
  assign fifo_pop       = deq;
  assign fifo_push      = resp_live;
`endif

  // In-flight request reserves a slot so its data always has somewhere to land.
  assign occupancy     = (CW+1)'(fifo_count) + (CW+1)'(outstanding_q) - (CW+1)'(deq);
  assign bus.icache_re = ~reset & ~bus.redirect_valid & (occupancy < (CW+1)'(FIFO_DEPTH));
  assign bus.icache_addr = fetch_pc_q;
  assign accept        = bus.icache_re & ~bus.stall;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    kill_d        = kill_q;
    if (bus.redirect_valid) begin
      fetch_pc_d    = {bus.redirect_pc[XLEN-1:2], 2'b00};
      outstanding_d = outstanding_q & bus.stall;
      kill_d        = outstanding_q & bus.stall;
    end else begin
      if (resp) begin
        outstanding_d = 1'b0;
        kill_d        = 1'b0;
      end
      if (accept) begin
        outstanding_d = 1'b1;
        req_pc_d      = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
    end
  end

  riscv_fetch_unit_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect_valid),
    .push      (fifo_push),
    .push_data ({req_pc_q, bus.icache_dout}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb/tb_riscv_fetch_unit.sv - scoreboard bench for riscv_fetch_unit
module tb_riscv_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;
  localparam logic [31:0] RPC   = 32'h0000_2000;
`ifdef FETCH_BYPASS_EN
  localparam int LAT_FIRST = 1;
  localparam int LAT_REDIR = 2;
`else
  localparam int LAT_FIRST = 2;
  localparam int LAT_REDIR = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_fetch_unit_if #(.XLEN(32), .ILEN(32)) bus ();

  riscv_fetch_unit #(
    .XLEN       (32),
    .ILEN       (32),
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] model_pc = RPC;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Memory model plus scoreboard: every accepted fetch queues the instruction that
  // program order says must reach decode; a redirect squashes everything queued.
  initial begin : monitor
    logic        prev_hold;
    logic [31:0] prev_addr;
    logic        mem_valid_nx;
    logic [31:0] mem_addr_nx;
    logic [31:0] epc, einst;
    prev_hold    = 1'b0;
    prev_addr    = 32'h0;
    mem_valid_nx = 1'b0;
    mem_addr_nx  = 32'h0;
    bus.icache_dout = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        exp_pc_q.delete();
        exp_inst_q.delete();
        model_pc     = RPC;
        mem_valid_nx = 1'b0;
        prev_hold    = 1'b0;
      end else begin
        if (prev_hold) begin
          check("stall_addr_hold", bus.icache_addr, prev_addr);
          if (!bus.redirect_valid) check("stall_re_hold", 32'(bus.icache_re), 32'd1);
        end
        if (bus.redirect_valid) begin
          check("redirect_inst_valid", 32'(bus.inst_valid), 32'd0);
          check("redirect_icache_re", 32'(bus.icache_re), 32'd0);
        end
        if (bus.inst_valid && bus.inst_ready) begin
          if (exp_pc_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_inst: got pc %08h expected no instruction", bus.inst_pc);
          end else begin
            epc   = exp_pc_q.pop_front();
            einst = exp_inst_q.pop_front();
            check("inst_pc", bus.inst_pc, epc);
            check("inst", bus.inst, einst);
          end
        end
        if (bus.icache_re && !bus.stall) begin
          check("fetch_addr", bus.icache_addr, model_pc);
          exp_pc_q.push_back(model_pc);
          exp_inst_q.push_back(model_pc ^ KEY);
          model_pc     = model_pc + 32'd4;
          mem_valid_nx = 1'b1;
          mem_addr_nx  = bus.icache_addr;
        end else if (!bus.stall) begin
          mem_valid_nx = 1'b0;
        end
        if (bus.redirect_valid) begin
          exp_pc_q.delete();
          exp_inst_q.delete();
          model_pc = bus.redirect_pc & 32'hFFFF_FFFC;
        end
        check("occupancy_bound", 32'(exp_pc_q.size() <= DEPTH), 32'd1);
        prev_hold = bus.stall && bus.icache_re && !bus.redirect_valid;
        prev_addr = bus.icache_addr;
      end
      @(posedge clk);
      #1;
      mem_valid = mem_valid_nx;
      mem_addr  = mem_addr_nx;
      bus.icache_dout = mem_valid ? (mem_addr ^ KEY) : $urandom;
    end
  end

  task automatic drive(input logic s, input logic r, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    bus.stall          = s;
    bus.inst_ready     = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #3;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!bus.inst_valid && k < 20) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      k++;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stimulus
    int          k;
    int          n;
    logic [31:0] a0;
    bus.stall          = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    repeat (3) @(negedge clk);
    #3;
    check("reset_icache_re", 32'(bus.icache_re), 32'd0);
    check("reset_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("reset_icache_addr", bus.icache_addr, RPC);
    check("reset_inst", bus.inst, 32'h0);
    check("reset_inst_pc", bus.inst_pc, 32'h0);

    // Streaming from reset
    @(negedge clk);
    rst            = 1'b0;
    bus.inst_ready = 1'b1;
    #3;
    check("first_req_re", 32'(bus.icache_re), 32'd1);
    check("first_req_addr", bus.icache_addr, RPC);
    wait_valid(k);
    check("first_latency", 32'(k), 32'(LAT_FIRST));
    check("first_inst_pc", bus.inst_pc, RPC);
    n = 0;
    repeat (10) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      if (bus.inst_valid) n++;
    end
    check("throughput", 32'(n), 32'd10);

    // Decode back-pressure fills the buffer and halts requests
    repeat (10) drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("backpressure_re", 32'(bus.icache_re), 32'd0);
    check("backpressure_valid", 32'(bus.inst_valid), 32'd1);
    repeat (10) drive(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect with a full buffer
    repeat (4) drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_3000);
    check("redir3000_valid", 32'(bus.inst_valid), 32'd0);
    wait_valid(k);
    check("redir_latency", 32'(k), 32'(LAT_REDIR));
    check("redir3000_pc", bus.inst_pc, 32'h0000_3000);
    repeat (6) drive(1'b0, 1'b1, 1'b0, 32'h0);

    // Memory stall mid-stream
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    a0 = bus.icache_addr;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      check("stall_addr_const", bus.icache_addr, a0);
    end
    repeat (8) drive(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect under stall with a request in flight
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_4000);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    wait_valid(k);
    check("redir4000_seen", 32'(bus.inst_valid), 32'd1);
    check("redir4000_pc", bus.inst_pc, 32'h0000_4000);
    repeat (6) drive(1'b0, 1'b1, 1'b0, 32'h0);

    // Misaligned redirect near the top of the address space wraps to zero
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFA);
    wait_valid(k);
    check("wrap_first_pc", bus.inst_pc, 32'hFFFF_FFF8);
    repeat (8) drive(1'b0, 1'b1, 1'b0, 32'h0);

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.inst_valid), 32'd0);
    check("async_rst_re", 32'(bus.icache_re), 32'd0);
    check("async_rst_addr", bus.icache_addr, RPC);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3;
    check("restart_re", 32'(bus.icache_re), 32'd1);
    check("restart_addr", bus.icache_addr, RPC);
    wait_valid(k);
    check("restart_pc", bus.inst_pc, RPC);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0,
            32'h0001_0000 + ($urandom_range(0, 1023) << 2) + $urandom_range(0, 3));
    end
    repeat (10) drive(1'b0, 1'b1, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
